seg_scan_driver: RTL and testbench

Time-multiplexed driver for the 4-digit common-anode seven-segment display. It sits directly downstream of the display controller and consumes its four registered 8-bit segment patterns (segOut0..segOut3). It scans them onto the shared cathode bus one digit at a time, with a ghost-suppression blanking guard and 8-level brightness control. It captures a fresh set of patterns only at frame boundaries, so a digit set never tears mid-frame.

---
 rtl/seg_pkg.sv | 60 ++++++
 rtl/seg_scan_driver_if.sv | 26 ++
 rtl/seg_scan_timer.sv | 54 +++++
 rtl/seg_scan_driver.sv | 112 +++++++++++
 tb/tb_seg_scan_driver.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: digit count, blank pattern, anode
// selects and the active-low segment encodings used by the display path.
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Anode select per digit position; digit 0 is the leftmost and uses An[3].
    localparam logic [3:0] AN_DIG0 = 4'b0111;
    localparam logic [3:0] AN_DIG1 = 4'b1011;
    localparam logic [3:0] AN_DIG2 = 4'b1101;
    localparam logic [3:0] AN_DIG3 = 4'b1110;

    // Letter patterns for the "LOSE" message (active-low, dp off).
    localparam logic [7:0] SEG_L = 8'hC7;
    localparam logic [7:0] SEG_O = 8'hC0;
    localparam logic [7:0] SEG_S = 8'h92;
    localparam logic [7:0] SEG_E = 8'h86;

    // Slot phase as seen by the output decode.
    typedef enum logic [1:0] {
        PH_BLANK,
        PH_LIT,
        PH_DARK
    } phase_t;

    // Decimal digit to active-low segment pattern, bit 7 = dp (kept off).
    function automatic logic [7:0] seg_digit(input logic [3:0] d);
        logic [7:0] p;
        case (d)
            4'd0:    p = 8'hC0;
            4'd1:    p = 8'hF9;
            4'd2:    p = 8'hA4;
            4'd3:    p = 8'hB0;
            4'd4:    p = 8'h99;
            4'd5:    p = 8'h92;
            4'd6:    p = 8'h82;
            4'd7:    p = 8'hF8;
            4'd8:    p = 8'h80;
            4'd9:    p = 8'h90;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

    // Scan index to active-low anode vector.
    function automatic logic [3:0] an_select(input logic [1:0] idx);
        logic [3:0] a;
        case (idx)
            2'd0:    a = AN_DIG0;
            2'd1:    a = AN_DIG1;
            2'd2:    a = AN_DIG2;
            default: a = AN_DIG3;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display-side bundle: scan controls and patterns in, anode/cathode drive out.
interface seg_scan_if;
    import seg_pkg::*;

    logic                  En;
    logic [2:0]            Bright;
    logic [7:0]            SegIn0;
    logic [7:0]            SegIn1;
    logic [7:0]            SegIn2;
    logic [7:0]            SegIn3;
    logic [NUM_DIGITS-1:0] An;
    logic [7:0]            Seg;
    logic                  FrameStart;

    // Pattern source / controller side.
    modport master (
        output En, Bright, SegIn0, SegIn1, SegIn2, SegIn3,
        input  An, Seg, FrameStart
    );

    // Scan driver side.
    modport slave (
        input  En, Bright, SegIn0, SegIn1, SegIn2, SegIn3,
        output An, Seg, FrameStart
    );
endinterface

// File: rtl/seg_scan_timer.sv
// Slot timer for the display scan: position within a digit slot, the digit
// being scanned, and the strobe marking the edge that latches a new frame.
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int CNT_W        = $clog2(DIGIT_CYCLES)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [1:0]       idx_o,
    output logic [CNT_W-1:0] slot_cnt_o,
    output logic             frame_latch_o
);

    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]       idx_q, idx_d;

    // Advance through the slot; at the last cycle move to the next digit.
    always_comb begin
        slot_cnt_d = slot_cnt_q;
        idx_d      = idx_q;
        if (!en_i) begin
            slot_cnt_d = '0;
            idx_d      = 2'd0;
        end else if (slot_cnt_q == CNT_W'(DIGIT_CYCLES - 1)) begin
            slot_cnt_d = '0;
            if (idx_q == 2'(NUM_DIGITS - 1)) begin
                idx_d = 2'd0;
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end else begin
            slot_cnt_d = slot_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers; reset parks the scan at frame start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_cnt_q <= '0;
            idx_q      <= 2'd0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            idx_q      <= idx_d;
        end
    end

    assign frame_latch_o = en_i && (slot_cnt_q == '0) && (idx_q == 2'd0);
    assign idx_o         = idx_q;
    assign slot_cnt_o    = slot_cnt_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed four-digit scan with per-slot blanking guard and
// eight-level brightness. Patterns are shadowed once per frame so a digit
// set never tears mid-scan.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input logic       Clk100M,
    input logic       Rst,
    seg_scan_if.slave bus
);

    localparam int ON_STEP = (DIGIT_CYCLES - BLANK_CYCLES) / 8;
    localparam int CNT_W   = $clog2(DIGIT_CYCLES);
    // One extra bit of headroom so BLANK + 8*ON_STEP (up to DIGIT_CYCLES) fits.
    localparam int LIM_W   = $clog2(DIGIT_CYCLES + 1);

    logic [CNT_W-1:0] slot_cnt;
    logic [1:0]       idx;
    logic             frame_latch;

    logic [7:0]       shadow_q [NUM_DIGITS];
    logic [7:0]       shadow_d [NUM_DIGITS];

    logic [LIM_W-1:0] slot_ext;
    logic [LIM_W-1:0] lit_end;
    phase_t           phase;

    logic [3:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;
    logic             fs_q, fs_d;

    seg_scan_timer #(
        .DIGIT_CYCLES (DIGIT_CYCLES),
        .CNT_W        (CNT_W)
    ) u_timer (
        .clk_i         (Clk100M),
        .rst_i         (Rst),
        .en_i          (bus.En),
        .idx_o         (idx),
        .slot_cnt_o    (slot_cnt),
        .frame_latch_o (frame_latch)
    );

    // Capture a fresh pattern set only on the frame-start edge.
    always_comb begin
        shadow_d = shadow_q;
        if (frame_latch) begin
            shadow_d[0] = bus.SegIn0;
            shadow_d[1] = bus.SegIn1;
            shadow_d[2] = bus.SegIn2;
            shadow_d[3] = bus.SegIn3;
        end
    end

    // Shadow pattern registers.
    always_ff @(posedge Clk100M) begin
        if (Rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= SEG_BLANK;
            end
        end else begin
            shadow_q <= shadow_d;
        end
    end

    // Lit window end scales with the live brightness setting.
    assign slot_ext = LIM_W'(slot_cnt);
    assign lit_end  = LIM_W'(BLANK_CYCLES)
                    + LIM_W'(ON_STEP) * LIM_W'({1'b0, bus.Bright} + 4'd1);

    // Classify the current slot position into blank / lit / dark.
    always_comb begin
        phase = PH_DARK;
        if (slot_ext < LIM_W'(BLANK_CYCLES)) begin
            phase = PH_BLANK;
        end else if (slot_ext < lit_end) begin
            phase = PH_LIT;
        end
    end

    // Next output values; anything but an enabled lit cycle is dark.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        fs_d  = frame_latch;
        if (bus.En && (phase == PH_LIT)) begin
            an_d  = an_select(idx);
            seg_d = shadow_q[idx];
        end
    end

    // Output registers; reset forces the display dark.
    always_ff @(posedge Clk100M) begin
        if (Rst) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_BLANK;
            fs_q  <= 1'b0;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            fs_q  <= fs_d;
        end
    end

    assign bus.An         = an_q;
    assign bus.Seg        = seg_q;
    assign bus.FrameStart = fs_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed and randomized checks for seg_scan_driver with a 16-cycle slot
// and a 2-cycle blanking guard (one lit cycle per brightness step).
module tb_seg_scan_driver;
    import seg_pkg::*;

    localparam int DC = 16;
    localparam int BC = 2;

    localparam logic [31:0] PAT_LOSE = {8'h86, 8'h92, 8'hC0, 8'hC7};
    localparam logic [31:0] PAT_MOD  = {8'h86, 8'hA4, 8'hC0, 8'hF9};
    localparam logic [31:0] PAT_DROP = {8'h86, 8'h92, 8'hC0, 8'h80};
    localparam logic [31:0] PAT_1234 = {8'h99, 8'hB0, 8'hA4, 8'hF9};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    seg_scan_if bus ();

    seg_scan_driver #(
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC)
    ) dut (
        .Clk100M (clk),
        .Rst     (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Expected anode for cycle k after a frame latch at k=0.
    function automatic logic [3:0] exp_an(input int k, input int b);
        int s;
        int d;
        s = k % DC;
        d = (k / DC) % 4;
        if (s >= BC && s < BC + b + 1) return 4'b1111 ^ (4'b1000 >> d);
        return 4'b1111;
    endfunction

    function automatic logic [7:0] exp_seg(input int k, input int b, input logic [31:0] p);
        int s;
        int d;
        s = k % DC;
        d = (k / DC) % 4;
        if (s >= BC && s < BC + b + 1) return p[8*d +: 8];
        return 8'hFF;
    endfunction

    task automatic set_pats(input logic [31:0] p);
        bus.SegIn0 = p[7:0];
        bus.SegIn1 = p[15:8];
        bus.SegIn2 = p[23:16];
        bus.SegIn3 = p[31:24];
    endtask

    // Park the scan for one edge, then enable so the next edge latches (k=0).
    task automatic restart(input int b, input logic [31:0] p);
        @(negedge clk);
        bus.En     = 1'b0;
        bus.Bright = 3'(b);
        set_pats(p);
        @(negedge clk);
        bus.En = 1'b1;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.En     = 1'b1;
        bus.Bright = 3'd7;
        set_pats(PAT_LOSE);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.An !== 4'b1111) begin
            errors++;
            $display("FAIL reset_an got %b want 1111", bus.An);
        end
        checks++;
        if (bus.Seg !== 8'hFF) begin
            errors++;
            $display("FAIL reset_seg got %h want ff", bus.Seg);
        end
        checks++;
        if (bus.FrameStart !== 1'b0) begin
            errors++;
            $display("FAIL reset_fs got %b want 0", bus.FrameStart);
        end
        rst    = 1'b0;
        bus.En = 1'b0;
    endtask

    task automatic test_scan(input int b);
        restart(b, PAT_LOSE);
        for (int k = 0; k <= 4 * DC; k++) begin
            @(negedge clk);
            checks++;
            if (bus.An !== exp_an(k, b)) begin
                errors++;
                $display("FAIL scan_an b=%0d k=%0d got %b want %b", b, k, bus.An, exp_an(k, b));
            end
            checks++;
            if (bus.Seg !== exp_seg(k, b, PAT_LOSE)) begin
                errors++;
                $display("FAIL scan_seg b=%0d k=%0d got %h want %h", b, k, bus.Seg, exp_seg(k, b, PAT_LOSE));
            end
            checks++;
            if (bus.FrameStart !== ((k % (4 * DC)) == 0)) begin
                errors++;
                $display("FAIL scan_fs b=%0d k=%0d got %b", b, k, bus.FrameStart);
            end
        end
    endtask

    task automatic test_frame_latch();
        logic [31:0] p;
        restart(7, PAT_LOSE);
        for (int k = 0; k < 5 * DC; k++) begin
            @(negedge clk);
            p = (k < 4 * DC) ? PAT_LOSE : PAT_MOD;
            checks++;
            if (bus.An !== exp_an(k, 7)) begin
                errors++;
                $display("FAIL latch_an k=%0d got %b want %b", k, bus.An, exp_an(k, 7));
            end
            checks++;
            if (bus.Seg !== exp_seg(k, 7, p)) begin
                errors++;
                $display("FAIL latch_seg k=%0d got %h want %h", k, bus.Seg, exp_seg(k, 7, p));
            end
            if (k == 4 * DC) begin
                checks++;
                if (bus.FrameStart !== 1'b1) begin
                    errors++;
                    $display("FAIL latch_fs k=%0d got %b want 1", k, bus.FrameStart);
                end
            end
            if (k == 3)  bus.SegIn0 = 8'hF9;
            if (k == 39) bus.SegIn2 = 8'hA4;
        end
    endtask

    task automatic test_en_drop();
        restart(7, PAT_LOSE);
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            checks++;
            if (bus.An !== exp_an(k, 7) || bus.Seg !== exp_seg(k, 7, PAT_LOSE)) begin
                errors++;
                $display("FAIL drop_pre k=%0d got %b/%h want %b/%h", k, bus.An, bus.Seg,
                         exp_an(k, 7), exp_seg(k, 7, PAT_LOSE));
            end
        end
        bus.En     = 1'b0;
        bus.SegIn0 = 8'h80;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            checks++;
            if (bus.An !== 4'b1111 || bus.Seg !== 8'hFF || bus.FrameStart !== 1'b0) begin
                errors++;
                $display("FAIL drop_dark j=%0d got %b/%h/%b want 1111/ff/0", j, bus.An, bus.Seg, bus.FrameStart);
            end
        end
        bus.En = 1'b1;
        for (int k = 0; k <= 24; k++) begin
            @(negedge clk);
            checks++;
            if (bus.An !== exp_an(k, 7) || bus.Seg !== exp_seg(k, 7, PAT_DROP)) begin
                errors++;
                $display("FAIL drop_post k=%0d got %b/%h want %b/%h", k, bus.An, bus.Seg,
                         exp_an(k, 7), exp_seg(k, 7, PAT_DROP));
            end
            checks++;
            if (bus.FrameStart !== (k == 0)) begin
                errors++;
                $display("FAIL drop_fs k=%0d got %b", k, bus.FrameStart);
            end
        end
    endtask

    task automatic test_reset_mid();
        restart(7, PAT_LOSE);
        for (int k = 0; k <= 36; k++) begin
            @(negedge clk);
            checks++;
            if (bus.An !== exp_an(k, 7) || bus.Seg !== exp_seg(k, 7, PAT_LOSE)) begin
                errors++;
                $display("FAIL rmid_pre k=%0d got %b/%h want %b/%h", k, bus.An, bus.Seg,
                         exp_an(k, 7), exp_seg(k, 7, PAT_LOSE));
            end
        end
        rst = 1'b1;
        set_pats(PAT_1234);
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            checks++;
            if (bus.An !== 4'b1111 || bus.Seg !== 8'hFF || bus.FrameStart !== 1'b0) begin
                errors++;
                $display("FAIL rmid_dark j=%0d got %b/%h/%b want 1111/ff/0", j, bus.An, bus.Seg, bus.FrameStart);
            end
        end
        rst = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            checks++;
            if (bus.An !== exp_an(k, 7) || bus.Seg !== exp_seg(k, 7, PAT_1234)) begin
                errors++;
                $display("FAIL rmid_post k=%0d got %b/%h want %b/%h", k, bus.An, bus.Seg,
                         exp_an(k, 7), exp_seg(k, 7, PAT_1234));
            end
            checks++;
            if (bus.FrameStart !== (k == 0)) begin
                errors++;
                $display("FAIL rmid_fs k=%0d got %b", k, bus.FrameStart);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] an;
        logic [7:0] seg;
        logic [3:0] prev_an;
        logic [7:0] prev_seg;
        logic [3:0] last_an;
        int         off_cnt;
        prev_an  = 4'b1111;
        prev_seg = 8'hFF;
        last_an  = 4'b1111;
        off_cnt  = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            an  = bus.An;
            seg = bus.Seg;
            checks++;
            if (!(an == 4'b1111 || an == 4'b0111 || an == 4'b1011 || an == 4'b1101 || an == 4'b1110)) begin
                errors++;
                $display("FAIL rand_onehot c=%0d got %b", c, an);
            end
            if (an == 4'b1111) begin
                checks++;
                if (seg !== 8'hFF) begin
                    errors++;
                    $display("FAIL rand_dark_seg c=%0d got %h want ff", c, seg);
                end
                off_cnt++;
            end else begin
                if (last_an != 4'b1111 && an != last_an) begin
                    checks++;
                    if (off_cnt < BC) begin
                        errors++;
                        $display("FAIL rand_gap c=%0d got %0d blank cycles want >= %0d", c, off_cnt, BC);
                    end
                end
                if (prev_an == an) begin
                    checks++;
                    if (seg !== prev_seg) begin
                        errors++;
                        $display("FAIL rand_stable c=%0d got %h want %h", c, seg, prev_seg);
                    end
                end
                last_an = an;
                off_cnt = 0;
            end
            prev_an  = an;
            prev_seg = seg;
            bus.En     = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 15) == 0) bus.Bright = 3'($urandom_range(0, 7));
            bus.SegIn0 = 8'($urandom);
            bus.SegIn1 = 8'($urandom);
            bus.SegIn2 = 8'($urandom);
            bus.SegIn3 = 8'($urandom);
        end
    endtask

    initial begin
        bus.En     = 1'b0;
        bus.Bright = 3'd0;
        set_pats(PAT_LOSE);
        test_reset();
        test_scan(7);
        test_scan(0);
        test_scan(3);
        test_frame_latch();
        test_en_drop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
